// File: rtl/addsub_serial_if.sv
// Operand/result bundle for the serial add/subtract unit.
// The master side issues start with operands; the slave side reports
// busy/done and holds the result until the next accepted start.
interface addsub_serial_if #(
   parameter int N = 8
);
   logic         start;
   logic         op;
   logic         sgn;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] out;
   logic         err;
   logic         carry;

   modport master (
      output start, op, sgn, a, b,
      input  busy, done, out, err, carry
   );

   modport slave (
      input  start, op, sgn, a, b,
      output busy, done, out, err, carry
   );
endinterface

// File: rtl/addsub_serial.sv
// Multi-cycle add/subtract: an N-bit operation is processed K bits per cycle,
// least significant slice first, then flags and optional clamping are applied.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for start; result registers hold the previous result
// RUN   | one K-bit slice added per cycle, running carry kept in c_r
// FIN   | flags/saturation computed, result published, done next cycle
module addsub_serial #(
   parameter int N   = 8,
   parameter int K   = 2,
   parameter int SAT = 0
) (
   input logic           clk,
   input logic           rst,
   addsub_serial_if.slave bus
);
   localparam int S  = N / K;
   localparam int IW = (S > 1) ? $clog2(S) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;

   if ((N % K) != 0) begin : g_bad_slice
      $error("addsub_serial: N must be a multiple of K");
   end

   logic [1:0]    state;
   logic [N-1:0]  a_sh;
   logic [N-1:0]  b_sh;
   logic [N-1:0]  res;
   logic [IW-1:0] idx;
   logic          c_r;
   logic          op_r;
   logic          sgn_r;
   logic          a_msb;
   logic          b_msb;
   logic          busy_r;
   logic          done_r;
   logic [N-1:0]  out_r;
   logic          err_r;
   logic          carry_r;

   logic [N-1:0]  b_in;
   logic [K:0]    slice_sum;
   logic          ovf;
   logic          err_n;
   logic [N-1:0]  res_n;

   // Subtraction is a + ~b + 1: invert b at latch time, carry-in comes from op.
   always_comb begin
      b_in = bus.op ? ~bus.b : bus.b;
   end

   // Low slice of the shifting operands plus the running carry.
   always_comb begin
      slice_sum = {1'b0, a_sh[K-1:0]} + {1'b0, b_sh[K-1:0]} + {{K{1'b0}}, c_r};
   end

   // Range error and clamped result, evaluated on the full raw sum in FIN.
   always_comb begin
      ovf   = (a_msb == b_msb) && (res[N-1] != a_msb);
      err_n = 1'b0;
      res_n = res;
      if (sgn_r) begin
         err_n = ovf;
      end else begin
         err_n = op_r ? ~c_r : c_r;
      end
      if ((SAT != 0) && err_n) begin
         if (!sgn_r) begin
            res_n = op_r ? {N{1'b0}} : {N{1'b1}};
         end else begin
            res_n = a_msb ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
         end
      end
   end

   // Sequencer: latch on start, one slice per RUN cycle, publish in FIN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         res     <= '0;
         idx     <= '0;
         c_r     <= 1'b0;
         op_r    <= 1'b0;
         sgn_r   <= 1'b0;
         a_msb   <= 1'b0;
         b_msb   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         out_r   <= '0;
         err_r   <= 1'b0;
         carry_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_sh   <= bus.a;
                  b_sh   <= b_in;
                  a_msb  <= bus.a[N-1];
                  b_msb  <= b_in[N-1];
                  op_r   <= bus.op;
                  sgn_r  <= bus.sgn;
                  c_r    <= bus.op;
                  idx    <= '0;
                  res    <= '0;
                  busy_r <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               a_sh              <= a_sh >> K;
               b_sh              <= b_sh >> K;
               res[idx*K +: K]   <= slice_sum[K-1:0];
               c_r               <= slice_sum[K];
               idx               <= idx + 1'b1;
               if (idx == IW'(S - 1)) begin
                  busy_r <= 1'b0;
                  state  <= FIN;
               end
            end
            FIN: begin
               out_r   <= res_n;
               err_r   <= err_n;
               carry_r <= c_r;
               done_r  <= 1'b1;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.out   = out_r;
   assign bus.err   = err_r;
   assign bus.carry = carry_r;
endmodule
